// File: rtl/rflp_sram_param_pkg.sv
// Shared definitions for the rflp_sram_param RAM: clear-FSM state encodings,
// parity and address-width helpers.
package rflp_sram_param_pkg;

    localparam logic [0:0] RFLP_ST_INIT  = 1'b0;
    localparam logic [0:0] RFLP_ST_READY = 1'b1;

    // Even parity over a word zero-extended to 64 bits; callers cast to 64'(...).
    function automatic logic rflp_parity(input logic [63:0] v);
        return ^v;
    endfunction

    function automatic int rflp_addr_w(input int raw, input int caw);
        return raw + caw;
    endfunction

endpackage

// File: rtl/rflp_sram_param_init_ctrl.sv
// Post-reset clear sequencer: walks every address once after reset, holding
// BUSY until the last location has been written.
import rflp_sram_param_pkg::*;

module rflp_init_ctrl #(
    parameter int AW         = 8,
    parameter int CLR_ON_RST = 1
) (
    input  logic          clk_i,
    input  logic          nrst_i,
    output logic          busy_o,
    output logic [AW-1:0] init_addr_o,
    output logic          init_we_o
);

    logic [0:0]    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == RFLP_ST_INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == {AW{1'b1}})
                state_d = RFLP_ST_READY;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            state_q <= (CLR_ON_RST != 0) ? RFLP_ST_INIT : RFLP_ST_READY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy_o      = (state_q == RFLP_ST_INIT);
    assign init_addr_o = cnt_q;
    // A reset edge restarts the sweep, so it must not write the array itself.
    assign init_we_o   = busy_o && nrst_i;

endmodule

// File: rtl/rflp_sram_param.sv
// Parametrised single-port register-file SRAM with synchronous reset, post-reset
// clear sweep and per-bit write mask. `define RFLP_PARITY_EN adds stored parity + PERR.
import rflp_sram_param_pkg::*;

module rflp_sram_param #(
    parameter int            DW         = 12,
    parameter int            RAW        = 6,
    parameter int            CAW        = 2,
    parameter logic [DW-1:0] INIT_VAL   = {DW{1'b0}},
    parameter int            CLR_ON_RST = 1
) (
    input  logic           CLK,
    input  logic           NRST,
    input  logic           NCE,
    input  logic           NWRT,
    input  logic [RAW-1:0] RA,
    input  logic [CAW-1:0] CA,
    input  logic [DW-1:0]  DIN,
    input  logic [DW-1:0]  NBWE,
    output logic [DW-1:0]  DO,
`ifdef RFLP_PARITY_EN
    output logic           PERR,
`endif
    output logic           BUSY
);

    localparam int AW    = rflp_addr_w(RAW, CAW);
    localparam int DEPTH = 1 << AW;
`ifdef RFLP_PARITY_EN
    localparam int MW    = DW + 1;
`else
    localparam int MW    = DW;
`endif

    logic [MW-1:0] mem_q [DEPTH];

    logic          busy;
    logic [AW-1:0] init_addr;
    logic          init_we;

    rflp_init_ctrl #(
        .AW         (AW),
        .CLR_ON_RST (CLR_ON_RST)
    ) u_init (
        .clk_i       (CLK),
        .nrst_i      (NRST),
        .busy_o      (busy),
        .init_addr_o (init_addr),
        .init_we_o   (init_we)
    );

    logic [AW-1:0] addr;
    logic          addr_x;
    logic          acc_en, rd_en, wr_en;
    logic [MW-1:0] rd_word, wr_word, init_word;
    logic [DW-1:0] merged;

    assign addr   = {RA, CA};
    assign addr_x = $isunknown(addr);
    assign acc_en = NRST && !busy && !NCE;
    assign rd_en  = acc_en && NWRT;
    assign wr_en  = acc_en && !NWRT && !addr_x;

    assign rd_word = mem_q[addr];
    // NBWE bit low takes DIN, high keeps the stored bit.
    assign merged  = (rd_word[DW-1:0] & NBWE) | (DIN & ~NBWE);

`ifdef RFLP_PARITY_EN
    assign wr_word   = {rflp_parity(64'(merged)), merged};
    assign init_word = {rflp_parity(64'(INIT_VAL)), INIT_VAL};
`else
    assign wr_word   = merged;
    assign init_word = INIT_VAL;
`endif

    always_ff @(posedge CLK) begin
        if (init_we)
            mem_q[init_addr] <= init_word;
        else if (wr_en)
            mem_q[addr] <= wr_word;
    end

    logic [DW-1:0] do_q, do_d;

    always_comb begin
        do_d = do_q;
        if (rd_en)
            do_d = addr_x ? {DW{1'bx}} : rd_word[DW-1:0];
    end

    always_ff @(posedge CLK) begin
        if (!NRST)
            do_q <= '0;
        else
            do_q <= do_d;
    end

    assign DO   = do_q;
    assign BUSY = busy;

`ifdef RFLP_PARITY_EN
    logic perr_q, perr_d;

    always_comb begin
        perr_d = perr_q;
        if (rd_en)
            perr_d = !addr_x && (rflp_parity(64'(rd_word[DW-1:0])) != rd_word[DW]);
    end

    always_ff @(posedge CLK) begin
        if (!NRST)
            perr_q <= 1'b0;
        else
            perr_q <= perr_d;
    end

    assign PERR = perr_q;
`endif

endmodule
